audio_sfx_scheduler: RTL and testbench
======================================

# audio_sfx_scheduler

Sound-effect channel scheduler for the 4-channel audio mixer. It accepts one-shot tone requests from game logic and allocates each to one of the four tone-generator channels. It drives each channel's `period` and `mute` for the requested number of duration ticks, then releases the channel. It sits between game-logic requesters and the 4-channel audio bundle, on the HCLK domain.

## Interface

Parameters:
- `DURWIDTH`, default 8: width of the duration counter, in ticks.
- `PRIOWIDTH`, default 2: width of the request priority; a higher value means higher priority.
- Period width is `` `PERWIDTH `` from `audio_values.vh`; it is not a parameter.

Ports:
- Reset polarity and synchronicity: one clock; reset is asynchronous and active-high.
- `HCLK` input 1: sole clock.
- `reset` input 1: asynchronous, active-high reset.
- `tick` input 1: single-cycle duration strobe (e.g. frame rate).
- `stop_all` input 1: synchronous release of all channels.
- `req_valid` input 1: request present.
- `req_ready` output 1: the scheduler can accept the request this cycle.
- `req_period` input `` `PERWIDTH ``: tone period for the channel.
- `req_dur` input `DURWIDTH`: duration, in ticks.
- `req_prio` input `PRIOWIDTH`: request priority.
- `grant_valid` output 1: one-cycle pulse reporting an allocation.
- `grant_chan` output 2: channel index granted; valid with `grant_valid`.
- `busy` output 4: per-channel occupied flag.
- `mute` output 4: per-channel mute to the mixer; equals `~busy`.
- `period0`..`period3` output `` `PERWIDTH `` each: per-channel period to the mixer.

## Operation

- Per-channel state, all registered:
  - `busy`: 1 bit.
  - `prio`: `PRIOWIDTH` bits.
  - `remaining`: `DURWIDTH` bits.
  - `period`: `` `PERWIDTH `` bits.
- A request is accepted when `req_valid && req_ready` at a rising HCLK edge.
- `req_ready` is combinational from the registered state and the request inputs:
  - `req_ready = !stop_all && (any channel free || victim exists)`.
  - "Victim exists" applies only when preemption is compiled in; see Configuration.
- Channel selection:
  - First choice: the lowest-index free channel.
  - Otherwise, with preemption compiled in: the busy channel with the strictly lowest `prio` below `req_prio`. Ties go to the lowest index.
- On acceptance with `req_dur != 0`, the selected channel is loaded as follows:
  - `busy` is set to 1.
  - `prio` is loaded from `req_prio`.
  - `remaining` is loaded from `req_dur`.
  - `period` is loaded from `req_period`.
  - `grant_valid` is 1 for one cycle and `grant_chan` holds the selected index.
- On acceptance with `req_dur == 0`, the request is consumed and discarded:
  - No channel state changes.
  - `grant_valid` stays 0.
- On each `tick`, every busy channel not being loaded that cycle decrements `remaining`.
  - A channel whose `remaining` is 1 when a tick arrives clears `busy` instead of decrementing.
- Release keeps the `period` output at its last value; the tone is silenced via `mute` only.
- `stop_all` clears all `busy` bits. `period` outputs are held.

## Timing

- Values after reset:
  - `busy` = 0 and `mute` = 4'b1111.
  - `period0`..`period3` = 0.
  - `prio` and `remaining` = 0.
  - `grant_valid` = 0 and `grant_chan` = 0.
- Latency: the cycle after the accepting edge shows the new `busy`, `mute`, `period` and the `grant_valid` pulse, all registered.
- A request held over N ticks occupies its channel for exactly `req_dur` ticks. `mute` rises in the cycle after the edge that sampled the final tick.
- Simultaneous load and tick on the same channel: the load wins; `remaining` takes `req_dur` with no decrement.
- Simultaneous `stop_all` and `req_valid`: `req_ready` = 0 and all channels are released; the requester must hold the request.
- `req_*` inputs must remain stable while `req_valid && !req_ready`.
- Back-to-back accepts are allowed, one per cycle; each sees the state updated by the previous one.
- Assertion of `reset` mid-operation immediately forces the reset values, asynchronously.

## Configuration

- `AUDIO_SFX_PREEMPT_EN` defined:
  - Victim selection by priority is enabled.
  - `req_ready` can be 1 with all four channels busy.
- `AUDIO_SFX_PREEMPT_EN` undefined:
  - Only free channels are allocated.
  - `req_ready = !stop_all && (busy != 4'b1111)`.
  - `prio` storage may be optimized away.

## Test plan

- Reset release, idle:
  - Stimulus: reset, then 10 idle cycles.
  - Required: `mute` = 4'b1111, all periods 0, `req_ready` = 1, `grant_valid` never 1.
- Single request:
  - Stimulus: period=300, dur=3, prio=1; then 3 ticks spaced 5 cycles apart.
  - Required: `grant_chan` = 0 pulse one cycle after accept; `mute[0]` = 0 and `period0` = 300 until the cycle after the third tick; `mute[0]` = 1 afterwards with `period0` still 300.
- Fill all channels:
  - Stimulus: 4 back-to-back requests with prio=2, periods 100/200/300/400.
  - Required: grants to channels 0, 1, 2, 3 in order; `busy` = 4'b1111.
  - With preempt undefined: a fifth request sees `req_ready` = 0.
- Preemption (`AUDIO_SFX_PREEMPT_EN`):
  - Stimulus: channels hold prios 2, 1, 1, 3; new request with prio=2, period=555.
  - Required: `grant_chan` = 1 and `period1` = 555.
  - A further request with prio=1 sees `req_ready` = 0.
- Simultaneous events:
  - Stimulus: tick coincides with a reload of a busy channel.
  - Required: `remaining` = `req_dur`, with no decrement.
  - Stimulus: `stop_all` coincides with `req_valid`.
  - Required: `req_ready` = 0 and `busy` = 0 the next cycle.
- Zero duration and async reset:
  - Stimulus: `req_dur` = 0.
  - Required: accepted, with no grant and no state change.
  - Stimulus: `reset` asserted mid-note.
  - Required: `mute` = 4'b1111 in the same cycle, before any HCLK edge.

Source files
------------

// File: rtl/audio_sfx_scheduler_if.sv
// Request/grant handshake between game-logic requesters and the SFX scheduler.
// PERWIDTH mirrors audio_values.vh so the bundle elaborates standalone.
`ifndef PERWIDTH
`define PERWIDTH 12
`endif

interface audio_sfx_scheduler_if #(
  parameter int DURWIDTH  = 8,
  parameter int PRIOWIDTH = 2
);
  logic                  req_valid;
  logic                  req_ready;
  logic [`PERWIDTH-1:0]  req_period;
  logic [DURWIDTH-1:0]   req_dur;
  logic [PRIOWIDTH-1:0]  req_prio;
  logic                  grant_valid;
  logic [1:0]            grant_chan;

  modport master (
    output req_valid, req_period, req_dur, req_prio,
    input  req_ready, grant_valid, grant_chan
  );

  modport slave (
    input  req_valid, req_period, req_dur, req_prio,
    output req_ready, grant_valid, grant_chan
  );
endinterface

// File: rtl/audio_sfx_scheduler.sv
// Allocates one-shot tone requests to 4 mixer channels and times them out on tick.
// Build option: AUDIO_SFX_PREEMPT_EN enables priority-based preemption of busy channels.
`ifndef PERWIDTH
`define PERWIDTH 12
`endif

module audio_sfx_scheduler #(
  parameter int DURWIDTH  = 8,
  parameter int PRIOWIDTH = 2
) (
  input  logic                 HCLK,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 stop_all,
  audio_sfx_scheduler_if.slave req,
  output logic [3:0]           busy,
  output logic [3:0]           mute,
  output logic [`PERWIDTH-1:0] period0,
  output logic [`PERWIDTH-1:0] period1,
  output logic [`PERWIDTH-1:0] period2,
  output logic [`PERWIDTH-1:0] period3
);

  logic [3:0]                       busy_q, busy_d;
  logic [3:0][DURWIDTH-1:0]         rem_q, rem_d;
  logic [3:0][`PERWIDTH-1:0]        per_q, per_d;
  logic                             grant_vld_q, grant_vld_d;
  logic [1:0]                       grant_chan_q, grant_chan_d;

  logic                             free_vld;
  logic [1:0]                       free_idx;
  logic                             room;
  logic [1:0]                       sel;
  logic                             load;

`ifdef AUDIO_SFX_PREEMPT_EN
  logic [3:0][PRIOWIDTH-1:0]        prio_q, prio_d;
  logic                             vic_vld;
  logic [1:0]                       vic_idx;
  logic [PRIOWIDTH-1:0]             vic_prio;
`else
  logic                             unused_prio;
  assign unused_prio = ^req.req_prio;
`endif

  always_comb begin
    free_vld = 1'b0;
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = 2'(i);
      end
    end
`ifdef AUDIO_SFX_PREEMPT_EN
    // Strict '<' keeps the lowest index on ties and never evicts an equal priority.
    vic_vld  = 1'b0;
    vic_idx  = 2'd0;
    vic_prio = '0;
    for (int i = 0; i < 4; i++) begin
      if ((prio_q[i] < req.req_prio) && (!vic_vld || (prio_q[i] < vic_prio))) begin
        vic_vld  = 1'b1;
        vic_idx  = 2'(i);
        vic_prio = prio_q[i];
      end
    end
    room = free_vld || vic_vld;
    sel  = free_vld ? free_idx : vic_idx;
`else
    room = free_vld;
    sel  = free_idx;
`endif
  end

  assign req.req_ready = !stop_all && room;
  assign load = req.req_valid && req.req_ready && (req.req_dur != '0);

  always_comb begin
    busy_d       = busy_q;
    rem_d        = rem_q;
    per_d        = per_q;
`ifdef AUDIO_SFX_PREEMPT_EN
    prio_d       = prio_q;
`endif
    grant_vld_d  = load;
    grant_chan_d = load ? sel : grant_chan_q;
    for (int i = 0; i < 4; i++) begin
      if (stop_all) begin
        busy_d[i] = 1'b0;
      end else if (load && (sel == 2'(i))) begin
        // A load overrides a same-cycle tick on this channel.
        busy_d[i] = 1'b1;
        rem_d[i]  = req.req_dur;
        per_d[i]  = req.req_period;
`ifdef AUDIO_SFX_PREEMPT_EN
        prio_d[i] = req.req_prio;
`endif
      end else if (tick && busy_q[i]) begin
        if (rem_q[i] == DURWIDTH'(1)) begin
          busy_d[i] = 1'b0;
        end else begin
          rem_d[i] = rem_q[i] - DURWIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      rem_q        <= '0;
      per_q        <= '0;
      grant_vld_q  <= 1'b0;
      grant_chan_q <= 2'd0;
`ifdef AUDIO_SFX_PREEMPT_EN
      prio_q       <= '0;
`endif
    end else begin
      busy_q       <= busy_d;
      rem_q        <= rem_d;
      per_q        <= per_d;
      grant_vld_q  <= grant_vld_d;
      grant_chan_q <= grant_chan_d;
`ifdef AUDIO_SFX_PREEMPT_EN
      prio_q       <= prio_d;
`endif
    end
  end

  assign req.grant_valid = grant_vld_q;
  assign req.grant_chan  = grant_chan_q;
  assign busy            = busy_q;
  assign mute            = ~busy_q;
  assign period0         = per_q[0];
  assign period1         = per_q[1];
  assign period2         = per_q[2];
  assign period3         = per_q[3];

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Directed bench for audio_sfx_scheduler; inputs driven and outputs sampled on the falling edge.
`ifndef PERWIDTH
`define PERWIDTH 12
`endif

module tb_audio_sfx_scheduler;
  logic                 clk;
  logic                 rst;
  logic                 tick;
  logic                 stop_all;
  logic [3:0]           busy;
  logic [3:0]           mute;
  logic [`PERWIDTH-1:0] period0, period1, period2, period3;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef AUDIO_SFX_PREEMPT_EN
  localparam int PER0_FINAL = 900;
`else
  localparam int PER0_FINAL = 123;
`endif

  audio_sfx_scheduler_if rif ();

  audio_sfx_scheduler dut (
    .HCLK    (clk),
    .reset   (rst),
    .tick    (tick),
    .stop_all(stop_all),
    .req     (rif.slave),
    .busy    (busy),
    .mute    (mute),
    .period0 (period0),
    .period1 (period1),
    .period2 (period2),
    .period3 (period3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic v, input int per, input int dur, input int prio);
    rif.req_valid  = v;
    rif.req_period = `PERWIDTH'(per);
    rif.req_dur    = 8'(dur);
    rif.req_prio   = 2'(prio);
  endtask

  // One accepted request per call; leaves valid low afterwards.
  task automatic send(input int per, input int dur, input int prio);
    drive_req(1'b1, per, dur, prio);
    step();
    drive_req(1'b0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; stop_all = 1'b0;
    drive_req(1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_mute", 32'(mute), 'hF);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(rif.grant_valid), 0);
    check("rst_chan", 32'(rif.grant_chan), 0);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_grant", 32'(rif.grant_valid), 0);
    end
    check("idle_mute", 32'(mute), 'hF);
    check("idle_per", 32'(period0 | period1 | period2 | period3), 0);
    check("idle_ready", 32'(rif.req_ready), 1);

    // Single request, 3 ticks spaced 5 cycles apart
    send(300, 3, 1);
    check("single_gv", 32'(rif.grant_valid), 1);
    check("single_gc", 32'(rif.grant_chan), 0);
    check("single_mute", 32'(mute), 'hE);
    check("single_per", 32'(period0), 300);
    for (int k = 0; k < 3; k++) begin
      repeat (4) step();
      check("single_hold", 32'(mute[0]), 0);
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
    check("single_rel_mute", 32'(mute), 'hF);
    check("single_rel_per", 32'(period0), 300);

    // Fill all four channels back-to-back
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, (i + 1) * 100, 50, 2);
      step();
      check("fill_gv", 32'(rif.grant_valid), 1);
      check("fill_gc", 32'(rif.grant_chan), 32'(i));
    end
    drive_req(1'b0, 0, 0, 0);
    check("fill_busy", 32'(busy), 'hF);
    drive_req(1'b1, 999, 5, 2);
    #1 check("fill_eq_prio_ready", 32'(rif.req_ready), 0);
    drive_req(1'b1, 999, 5, 3);
`ifdef AUDIO_SFX_PREEMPT_EN
    #1 check("fill_hi_prio_ready", 32'(rif.req_ready), 1);
`else
    #1 check("fill_hi_prio_ready", 32'(rif.req_ready), 0);
`endif

    // stop_all together with a pending request
    stop_all = 1'b1;
    #1 check("stop_ready", 32'(rif.req_ready), 0);
    step();
    stop_all = 1'b0;
    drive_req(1'b0, 0, 0, 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_gv", 32'(rif.grant_valid), 0);
    check("stop_per3", 32'(period3), 400);

`ifdef AUDIO_SFX_PREEMPT_EN
    // Preemption: prios 2,1,1,3 then prio 2 evicts channel 1
    send(10, 50, 2); send(20, 50, 1); send(30, 50, 1); send(40, 50, 3);
    drive_req(1'b1, 555, 50, 2);
    #1 check("pre_ready", 32'(rif.req_ready), 1);
    step();
    drive_req(1'b1, 556, 50, 1);
    check("pre_gc", 32'(rif.grant_chan), 1);
    check("pre_per1", 32'(period1), 555);
    check("pre_busy", 32'(busy), 'hF);
    check("pre_low_ready", 32'(rif.req_ready), 0);
    drive_req(1'b0, 0, 0, 0);
    stop_all = 1'b1; step(); stop_all = 1'b0;
`endif

    // Load coinciding with tick: ch0 rem1 releases, ch1 4->3, ch2 loads 2 undecremented
    send(123, 1, 1);
    send(124, 4, 1);
    drive_req(1'b1, 125, 2, 1);
    tick = 1'b1;
    step();
    drive_req(1'b0, 0, 0, 0);
    check("tl_gc", 32'(rif.grant_chan), 2);
    check("tl_busy0", 32'(busy), 'h6);
    step();
    check("tl_busy1", 32'(busy), 'h6);
    step();
    check("tl_busy2", 32'(busy), 'h2);
    step();
    tick = 1'b0;
    check("tl_busy3", 32'(busy), 0);

`ifdef AUDIO_SFX_PREEMPT_EN
    // Reload of a busy (preempted) channel with a coincident tick
    send(600, 10, 0); send(601, 10, 0); send(602, 10, 0); send(603, 10, 0);
    drive_req(1'b1, 900, 2, 3);
    tick = 1'b1;
    step();
    drive_req(1'b0, 0, 0, 0);
    check("ptl_gc", 32'(rif.grant_chan), 0);
    check("ptl_busy0", 32'(busy), 'hF);
    step();
    check("ptl_busy1", 32'(busy), 'hF);
    step();
    tick = 1'b0;
    check("ptl_busy2", 32'(busy), 'hE);
    stop_all = 1'b1; step(); stop_all = 1'b0;
`endif

    // Zero duration: consumed, no grant, no state change
    drive_req(1'b1, 777, 0, 3);
    #1 check("zero_ready", 32'(rif.req_ready), 1);
    step();
    drive_req(1'b0, 0, 0, 0);
    check("zero_gv", 32'(rif.grant_valid), 0);
    check("zero_busy", 32'(busy), 0);
    check("zero_per0", 32'(period0), 32'(PER0_FINAL));

    // Asynchronous reset mid-note
    send(77, 20, 1);
    check("ar_pre_mute", 32'(mute), 'hE);
    #2 rst = 1'b1;
    #1;
    check("ar_mute", 32'(mute), 'hF);
    check("ar_per0", 32'(period0), 0);
    check("ar_gv", 32'(rif.grant_valid), 0);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
